// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: ID decode into ID/EX register with load-use stall, redirect flush and syscall drain FSM (CTRL_BRANCH_DELAY_EN keeps delay slot on redirect)
module ctrl_decode_pipe #(
  parameter int ALUOP_W = 3,
  parameter int REG_W = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [31:0]        instr,
  input  logic               redirect,
  input  logic               syscall_done,
  output logic               stall,
  output logic               ex_valid,
  output logic               ex_regDst,
  output logic               ex_jump,
  output logic               ex_jal,
  output logic               ex_jumpRegister,
  output logic               ex_branch,
  output logic               ex_memRead,
  output logic               ex_memToReg,
  output logic               ex_memWrite,
  output logic               ex_aluSrc,
  output logic               ex_regWrite,
  output logic [ALUOP_W-1:0] ex_aluOp,
  output logic [REG_W-1:0]   ex_rs,
  output logic [REG_W-1:0]   ex_rt,
  output logic [REG_W-1:0]   ex_rd,
  output logic               syscall_req
);
  typedef enum logic [1:0] {RUN, DRAIN, WAIT} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [5:0] op, fn;
  logic special, jr, sys, beq, bne, addi, addiu, ori, lw, sw;
  logic busy, load_use, kill;
  logic [2:0] aluop;
  logic [9:0] ctl;
  logic [REG_W-1:0] rs, rt, rd;
  logic unused_ok;
`ifdef CTRL_BRANCH_DELAY_EN
  assign unused_ok = ^{instr[10:6], redirect};
`else
  assign unused_ok = ^instr[10:6];
`endif
  assign syscall_req = state == WAIT;
  always_comb begin
    op = instr[31:26];
    fn = instr[5:0];
    special = op == 6'h00;
    jr = special & (fn == 6'h08);
    sys = special & (fn == 6'h0c);
    beq = op == 6'h04;
    bne = op == 6'h05;
    addi = op == 6'h08;
    addiu = op == 6'h09;
    ori = op == 6'h0d;
    lw = op == 6'h23;
    sw = op == 6'h2b;
    rs = REG_W'(instr[25:21]);
    rt = REG_W'(instr[20:16]);
    rd = REG_W'(instr[15:11]);
    aluop = special ? (fn == 6'h24 ? 3'b000 : fn == 6'h25 ? 3'b001 : fn == 6'h20 ? 3'b010 : fn == 6'h22 ? 3'b110 : 3'b111)
          : ori ? 3'b001 : (addi | addiu | lw | sw) ? 3'b010 : (beq | bne) ? 3'b110 : 3'b111;
    ctl = {special, (op == 6'h02) | (op == 6'h03) | jr, op == 6'h03, jr, beq | bne, lw, lw, sw,
           addi | addiu | ori | lw | sw, (special & ~jr & ~sys) | addi | addiu | ori | lw};
    busy = state != RUN;
    load_use = ex_valid & ex_memRead & (ex_rt != '0) & in_valid &
               ((ex_rt == rs) | ((ex_rt == rt) & (special | beq | bne | sw)));
    stall = busy | load_use;
`ifdef CTRL_BRANCH_DELAY_EN
    kill = stall;
`else
    kill = stall | (redirect & ~busy);
`endif
    state_nx = state == RUN ? ((~kill & in_valid & sys) ? DRAIN : RUN)
             : state == DRAIN ? ((cnt == 4'(DRAIN_CYCLES)) ? WAIT : DRAIN)
             : (syscall_done ? RUN : WAIT);
    cnt_nx = state == DRAIN ? cnt + 4'd1 : 4'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      ex_valid <= 1'b0;
      {ex_regDst, ex_jump, ex_jal, ex_jumpRegister, ex_branch, ex_memRead, ex_memToReg, ex_memWrite, ex_aluSrc, ex_regWrite} <= '0;
      ex_aluOp <= '0;
      ex_rs <= '0;
      ex_rt <= '0;
      ex_rd <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ex_valid <= ~kill & in_valid;
      {ex_regDst, ex_jump, ex_jal, ex_jumpRegister, ex_branch, ex_memRead, ex_memToReg, ex_memWrite, ex_aluSrc, ex_regWrite} <= kill ? '0 : ctl;
      ex_aluOp <= kill ? '0 : ALUOP_W'(aluop);
      if (!kill) begin
        ex_rs <= rs;
        ex_rt <= rt;
        ex_rd <= rd;
      end
    end
  end
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: randomized and directed check of ctrl_decode_pipe against a transaction-level reference model
module tb_ctrl_decode_pipe;
  localparam int DC = 3;
`ifdef CTRL_BRANCH_DELAY_EN
  localparam bit DELAY = 1'b1;
`else
  localparam bit DELAY = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, in_valid, redirect, syscall_done;
  logic [31:0] instr;
  logic stall, ex_valid, ex_regDst, ex_jump, ex_jal, ex_jumpRegister, ex_branch;
  logic ex_memRead, ex_memToReg, ex_memWrite, ex_aluSrc, ex_regWrite, syscall_req;
  logic [2:0] ex_aluOp;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic [28:0] got_ex;
  always #5 clk = ~clk;
  ctrl_decode_pipe #(.ALUOP_W(3), .REG_W(5), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .redirect(redirect),
    .syscall_done(syscall_done), .stall(stall), .ex_valid(ex_valid), .ex_regDst(ex_regDst),
    .ex_jump(ex_jump), .ex_jal(ex_jal), .ex_jumpRegister(ex_jumpRegister), .ex_branch(ex_branch),
    .ex_memRead(ex_memRead), .ex_memToReg(ex_memToReg), .ex_memWrite(ex_memWrite),
    .ex_aluSrc(ex_aluSrc), .ex_regWrite(ex_regWrite), .ex_aluOp(ex_aluOp), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .syscall_req(syscall_req)
  );
  assign got_ex = {ex_valid, ex_regDst, ex_jump, ex_jal, ex_jumpRegister, ex_branch, ex_memRead,
                   ex_memToReg, ex_memWrite, ex_aluSrc, ex_regWrite, ex_aluOp, ex_rs, ex_rt, ex_rd};
  typedef struct packed {
    logic dst, jmp, jal, jr, br, mr, m2r, mw, asrc, rw;
    logic [2:0] op;
  } ctl_t;
  typedef struct packed {
    logic v;
    ctl_t c;
    logic [4:0] rs, rt, rd;
  } ex_t;
  ex_t m_ex;
  int drain;
  logic m_req;
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic ctl_t ref_dec(input logic [31:0] i);
    ctl_t c;
    c = '0;
    c.op = 3'b111;
    case (i[31:26])
      6'h00: begin
        c.dst = 1'b1;
        c.rw = 1'b1;
        case (i[5:0])
          6'h20: c.op = 3'b010;
          6'h22: c.op = 3'b110;
          6'h24: c.op = 3'b000;
          6'h25: c.op = 3'b001;
          6'h08: begin c.jmp = 1'b1; c.jr = 1'b1; c.rw = 1'b0; end
          6'h0c: c.rw = 1'b0;
          default: ;
        endcase
      end
      6'h02: c.jmp = 1'b1;
      6'h03: begin c.jmp = 1'b1; c.jal = 1'b1; end
      6'h04, 6'h05: begin c.br = 1'b1; c.op = 3'b110; end
      6'h08, 6'h09: begin c.asrc = 1'b1; c.rw = 1'b1; c.op = 3'b010; end
      6'h0d: begin c.asrc = 1'b1; c.rw = 1'b1; c.op = 3'b001; end
      6'h23: begin c.mr = 1'b1; c.m2r = 1'b1; c.asrc = 1'b1; c.rw = 1'b1; c.op = 3'b010; end
      6'h2b: begin c.mw = 1'b1; c.asrc = 1'b1; c.op = 3'b010; end
      default: ;
    endcase
    return c;
  endfunction
  function automatic logic exp_stall();
    logic uses_rt;
    uses_rt = instr[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2b};
    if (drain > 0 || m_req) return 1'b1;
    return m_ex.v && m_ex.c.mr && m_ex.rt != 5'd0 && in_valid &&
           (m_ex.rt == instr[25:21] || (m_ex.rt == instr[20:16] && uses_rt));
  endfunction
  function automatic void model_edge(input logic st);
    logic busy, kill;
    if (rst) begin
      m_ex = '0;
      drain = 0;
      m_req = 1'b0;
      return;
    end
    busy = drain > 0 || m_req;
    kill = st || (redirect && !busy && !DELAY);
    if (kill) begin
      m_ex.v = 1'b0;
      m_ex.c = '0;
    end else begin
      m_ex.v = in_valid;
      m_ex.c = ref_dec(instr);
      m_ex.rs = instr[25:21];
      m_ex.rt = instr[20:16];
      m_ex.rd = instr[15:11];
    end
    if (m_req && syscall_done) m_req = 1'b0;
    else if (drain > 0) begin
      drain--;
      if (drain == 0) m_req = 1'b1;
    end
    if (!kill && in_valid && instr[31:26] == 6'h00 && instr[5:0] == 6'h0c) drain = DC + 1;
  endfunction
  task automatic cycle(input string tag, output logic st);
    #1;
    st = exp_stall();
    check({tag, "_stall"}, 32'(stall), 32'(st));
    @(posedge clk);
    model_edge(st);
    #1;
    check({tag, "_ex"}, 32'(got_ex), 32'(m_ex));
    check({tag, "_req"}, 32'(syscall_req), 32'(m_req));
  endtask
  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    i = $urandom;
    i[25:21] = 5'($urandom_range(0, 7));
    i[20:16] = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 13))
      0, 1, 2: i[31:26] = 6'h00;
      3: i[31:26] = 6'h02;
      4: i[31:26] = 6'h03;
      5: i[31:26] = 6'h04;
      6: i[31:26] = 6'h05;
      7: i[31:26] = 6'h08;
      8: i[31:26] = 6'h09;
      9: i[31:26] = 6'h0d;
      10, 11: i[31:26] = 6'h23;
      12: i[31:26] = 6'h2b;
      default: ;
    endcase
    if (i[31:26] == 6'h00)
      case ($urandom_range(0, 15))
        0, 1: i[5:0] = 6'h20;
        2: i[5:0] = 6'h22;
        3: i[5:0] = 6'h24;
        4: i[5:0] = 6'h25;
        5: i[5:0] = 6'h2a;
        6: i[5:0] = 6'h08;
        7: i[5:0] = 6'h0c;
        default: ;
      endcase
    return i;
  endfunction
  initial begin
    logic st;
    rst = 1'b1;
    in_valid = 1'b0;
    instr = '0;
    redirect = 1'b0;
    syscall_done = 1'b0;
    m_ex = '0;
    drain = 0;
    m_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex", 32'(got_ex), 32'(0));
    check("rst_req", 32'(syscall_req), 32'(0));
    check("rst_stall", 32'(stall), 32'(0));
    rst = 1'b0;
    in_valid = 1'b1;
    instr = 32'h00221820;
    cycle("add", st);
    check("add_lit", 32'(got_ex), 32'({1'b1, 10'b1000000001, 3'b010, 5'd1, 5'd2, 5'd3}));
    instr = 32'h8C220000;
    cycle("lw", st);
    instr = 32'h00441820;
    #1;
    check("lu_stall", 32'(stall), 32'(1));
    cycle("lu1", st);
    check("lu_bubble", 32'(ex_valid), 32'(0));
    cycle("lu2", st);
    check("lu_add", 32'({ex_valid, ex_rs, ex_rd}), 32'({1'b1, 5'd2, 5'd3}));
    instr = 32'h8C200000;
    cycle("lw0", st);
    instr = 32'h00041820;
    #1;
    check("lw0_nostall", 32'(stall), 32'(0));
    cycle("lw0_add", st);
    check("lw0_add_v", 32'(ex_valid), 32'(1));
    instr = 32'h10220004;
    cycle("beq", st);
    instr = 32'h34250007;
    redirect = 1'b1;
    cycle("ori_redir", st);
    redirect = 1'b0;
    check("redir_v", 32'(ex_valid), 32'(DELAY));
    instr = 32'h0000000C;
    cycle("sys", st);
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cycle("drain", st);
      check("sys_req_time", 32'(syscall_req), 32'(k >= 4));
    end
    syscall_done = 1'b1;
    cycle("done", st);
    syscall_done = 1'b0;
    check("done_req", 32'(syscall_req), 32'(0));
    check("done_stall", 32'(stall), 32'(0));
    in_valid = 1'b1;
    instr = 32'h0000000C;
    cycle("sys2", st);
    in_valid = 1'b0;
    repeat (4) cycle("drain2", st);
    check("sys2_req", 32'(syscall_req), 32'(1));
    rst = 1'b1;
    cycle("rst_wait", st);
    rst = 1'b0;
    check("rstw_req", 32'(syscall_req), 32'(0));
    check("rstw_v", 32'(ex_valid), 32'(0));
    check("rstw_stall", 32'(stall), 32'(0));
    syscall_done = 1'b1;
    cycle("late_done", st);
    syscall_done = 1'b0;
    cycle("after_done", st);
    check("late_done_req", 32'(syscall_req), 32'(0));
    in_valid = 1'b1;
    instr = 32'h03E00008;
    cycle("jr", st);
    check("jr_lit", 32'(got_ex), 32'({1'b1, 10'b1101000000, 3'b111, 5'd31, 5'd0, 5'd0}));
    instr = 32'hFC000000;
    cycle("unk", st);
    check("unk_lit", 32'(got_ex), 32'({1'b1, 10'b0, 3'b111, 15'd0}));
    st = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (!st) begin
        in_valid = $urandom_range(0, 7) != 0;
        instr = rand_instr();
      end
      redirect = $urandom_range(0, 9) == 0;
      syscall_done = m_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      rst = $urandom_range(0, 199) == 0;
      cycle("rnd", st);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
